// File: rtl/s298_bist_driver_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bist_pkg : state type, LFSR constants and step function for the s298 BIST driver. Rev 1.0
// ---------------------------------------------------------------------------
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEF_SEED  = 16'hACE1;

  // Right-shifting Galois step; a nonzero state never maps to zero.
  function automatic logic [15:0] galois_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_lfsr16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bist_lfsr16 : 16-bit Galois LFSR with parallel load and XOR input (MISR when din is used). Rev 1.0
// ---------------------------------------------------------------------------
module bist_lfsr16
  import bist_pkg::*;
#(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = galois_step(q_q) ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/s298_bist_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// s298_bist_driver : flush + pseudo-random pattern driver with MISR signature check. Rev 1.0
// ---------------------------------------------------------------------------
module s298_bist_driver
  import bist_pkg::*;
#(
  parameter int unsigned           PAT_W    = 3,
  parameter int unsigned           RSP_W    = 6,
  parameter int unsigned           CNT_W    = 8,
  parameter int unsigned           INIT_CYC = 2,
  parameter logic [PAT_W-1:0]      INIT_PAT = PAT_W'(3'b001),
  parameter int unsigned           RSP_LAT  = 1,
  parameter logic [15:0]           SEED     = DEF_SEED
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             START,
  input  logic [CNT_W-1:0] NPAT,
  input  logic [15:0]      GOLDEN,
  input  logic [RSP_W-1:0] RSP,
  output logic [PAT_W-1:0] PAT,
  output logic             PAT_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [15:0]      SIG
);

  bist_state_t        state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         ph_q;
  logic [RSP_LAT-1:0] pipe_q;
  logic [RSP_LAT-1:0] pipe_d;
  logic [PAT_W-1:0]   pat_q;
  logic               pv_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;

  logic        w_accept;
  logic        w_init_last;
  logic        w_pat_step;
  logic        w_cap;
  logic [15:0] w_rsp_ext;
  logic [15:0] w_lfsr_q;
  logic [15:0] w_misr_q;
  logic [15:0] w_sig_next;
  logic        w_unused_lfsr;

  always_comb begin
    w_accept    = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    w_init_last = (state_q == ST_INIT) && (ph_q == 4'(INIT_CYC - 1));
    // Advance the generator whenever the next pattern is taken from it.
    w_pat_step  = w_init_last || ((state_q == ST_RUN) && (cnt_q != CNT_W'(1)));
    w_cap       = pipe_q[RSP_LAT-1];
    w_rsp_ext   = 16'(RSP);
    w_sig_next  = w_cap ? (galois_step(w_misr_q) ^ w_rsp_ext) : w_misr_q;
    pipe_d      = RSP_LAT'({pipe_q, pv_q});
  end

  assign w_unused_lfsr = ^(w_lfsr_q >> PAT_W);

  bist_lfsr16 #(.RST_VAL(SEED)) u_pat_lfsr (
    .clk      (CK),
    .rst_n    (RN),
    .load     (w_accept),
    .load_val (SEED),
    .en       (w_pat_step),
    .din      (16'h0000),
    .q        (w_lfsr_q)
  );

  bist_lfsr16 #(.RST_VAL(16'h0000)) u_misr (
    .clk      (CK),
    .rst_n    (RN),
    .load     (w_accept),
    .load_val (16'h0000),
    .en       (w_cap),
    .din      (w_rsp_ext),
    .q        (w_misr_q)
  );

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ph_q    <= 4'd0;
      pipe_q  <= '0;
      pat_q   <= '0;
      pv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      pipe_q <= pipe_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            if (NPAT == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= (GOLDEN == 16'h0000);
            end else begin
              state_q <= ST_INIT;
              ph_q    <= 4'd0;
              cnt_q   <= NPAT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
              pat_q   <= INIT_PAT;
            end
          end
        end
        ST_INIT: begin
          if (w_init_last) begin
            state_q <= ST_RUN;
            pat_q   <= w_lfsr_q[PAT_W-1:0];
            pv_q    <= 1'b1;
          end else begin
            ph_q <= ph_q + 4'd1;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DRAIN;
            pv_q    <= 1'b0;
            ph_q    <= 4'd0;
          end else begin
            pat_q <= w_lfsr_q[PAT_W-1:0];
          end
        end
        ST_DRAIN: begin
          // The final capture lands on this same edge, so compare its result.
          if (ph_q == 4'(RSP_LAT - 1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (w_sig_next == GOLDEN);
          end else begin
            ph_q <= ph_q + 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign PAT       = pat_q;
  assign PAT_VALID = pv_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign SIG       = w_misr_q;

endmodule
`default_nettype wire

// File: tb/tb_s298_bist_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_s298_bist_driver : directed bench with a timeline model of the BIST run. Rev 1.0
// ---------------------------------------------------------------------------
module tb_s298_bist_driver;

  localparam int I_CYC = 2;
  localparam int DEPTH = 1024;

  logic        ck = 1'b0;
  logic        rn = 1'b0;
  logic        start [2];
  logic [7:0]  npat;
  logic [15:0] golden;
  logic [5:0]  rsp;

  logic [2:0]  pat  [2];
  logic        pv   [2];
  logic        busy [2];
  logic        done [2];
  logic        pass [2];
  logic [15:0] sig  [2];

  int checks = 0;
  int errors = 0;

  // Model state: one record for the latest accepted run of each instance.
  int          cyc = 0;
  bit          m_have     [2] = '{1'b0, 1'b0};
  int          m_r0       [2];
  int          m_n        [2];
  logic [15:0] m_gold     [2];
  logic [2:0]  m_prev_pat [2] = '{3'd0, 3'd0};
  logic [5:0]  m_rsp      [DEPTH];

  bit auto_rsp = 1'b0;
  int rsp_base = 0;

  always #5 ck = ~ck;

  s298_bist_driver u_dut (
    .CK(ck), .RN(rn), .START(start[0]), .NPAT(npat), .GOLDEN(golden), .RSP(rsp),
    .PAT(pat[0]), .PAT_VALID(pv[0]), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .SIG(sig[0])
  );

  s298_bist_driver #(.RSP_LAT(3)) u_dut_l3 (
    .CK(ck), .RN(rn), .START(start[1]), .NPAT(npat), .GOLDEN(golden), .RSP(rsp),
    .PAT(pat[1]), .PAT_VALID(pv[1]), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .SIG(sig[1])
  );

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int lat(input int inst);
    return (inst == 0) ? 1 : 3;
  endfunction

  function automatic logic [2:0] pat_at(input int j);
    logic [15:0] l;
    l = 16'hACE1;
    for (int s = 0; s < j; s++) l = lstep(l);
    return l[2:0];
  endfunction

  function automatic logic [5:0] rsp_fn(input int x);
    return 6'((x * 13 + 5) & 63);
  endfunction

  task automatic model_eval(input int inst, input int c, output logic [2:0] e_pat,
                            output logic e_pv, output logic e_busy, output logic e_done,
                            output logic e_pass, output logic [15:0] e_sig);
    int k, n, l, t;
    e_pat = m_prev_pat[inst];
    e_pv = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0; e_sig = 16'h0000;
    if (m_have[inst]) begin
      n = m_n[inst];
      l = lat(inst);
      k = c - m_r0[inst];
      if (n == 0) begin
        e_done = 1'b1;
        e_pass = (m_gold[inst] == 16'h0000);
      end else begin
        if (k <= I_CYC) begin
          e_pat = 3'b001; e_busy = 1'b1;
        end else if (k <= I_CYC + n) begin
          e_pat = pat_at(k - I_CYC - 1); e_pv = 1'b1; e_busy = 1'b1;
        end else begin
          e_pat  = pat_at(n - 1);
          e_busy = (k <= I_CYC + n + l);
          e_done = !e_busy;
        end
        for (int i = 0; i < n; i++) begin
          t = m_r0[inst] + I_CYC + 1 + i;
          if (t + l + 1 <= c) e_sig = lstep(e_sig) ^ {10'h000, m_rsp[(t + l) % DEPTH]};
        end
        e_pass = e_done && (e_sig == m_gold[inst]);
      end
    end
  endtask

  always @(posedge ck or negedge rn) begin : p_model
    logic [2:0]  a_pat;
    logic        a_pv, a_busy, a_done, a_pass;
    logic [15:0] a_sig;
    if (!rn) begin
      for (int i = 0; i < 2; i++) begin
        m_have[i]     <= 1'b0;
        m_prev_pat[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        model_eval(i, cyc, a_pat, a_pv, a_busy, a_done, a_pass, a_sig);
        if (start[i] && !a_busy) begin
          m_have[i]     <= 1'b1;
          m_r0[i]       <= cyc;
          m_n[i]        <= int'(npat);
          m_gold[i]     <= golden;
          m_prev_pat[i] <= a_pat;
        end
      end
      m_rsp[cyc % DEPTH] <= rsp;
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [2:0]  e_pat;
    logic        e_pv, e_busy, e_done, e_pass;
    logic [15:0] e_sig;
    for (int i = 0; i < 2; i++) begin
      model_eval(i, cyc, e_pat, e_pv, e_busy, e_done, e_pass, e_sig);
      chk($sformatf("u%0d_pat", i),  {13'h0, pat[i]},  {13'h0, e_pat});
      chk($sformatf("u%0d_pv", i),   {15'h0, pv[i]},   {15'h0, e_pv});
      chk($sformatf("u%0d_busy", i), {15'h0, busy[i]}, {15'h0, e_busy});
      chk($sformatf("u%0d_done", i), {15'h0, done[i]}, {15'h0, e_done});
      chk($sformatf("u%0d_pass", i), {15'h0, pass[i]}, {15'h0, e_pass});
      chk($sformatf("u%0d_sig", i),  sig[i],           e_sig);
    end
  endtask

  task automatic tick();
    @(negedge ck);
    compare_all();
    @(posedge ck);
    #1;
    if (auto_rsp) rsp = rsp_fn(cyc - rsp_base);
  endtask

  task automatic chk_zero(input int inst, input string tag);
    chk({tag, "_pat"},  {13'h0, pat[inst]},  16'h0);
    chk({tag, "_pv"},   {15'h0, pv[inst]},   16'h0);
    chk({tag, "_busy"}, {15'h0, busy[inst]}, 16'h0);
    chk({tag, "_done"}, {15'h0, done[inst]}, 16'h0);
    chk({tag, "_pass"}, {15'h0, pass[inst]}, 16'h0);
    chk({tag, "_sig"},  sig[inst],           16'h0);
  endtask

  task automatic wait_done(input int inst, input int budget, output int n);
    n = 0;
    while (!done[inst] && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("u%0d_done_timeout", inst), {15'h0, done[inst]}, 16'h1);
  endtask

  initial begin : p_stim
    logic [2:0]  seq [4];
    logic [15:0] exp6;
    int          n;
    int          pvcnt;

    seq = '{3'd1, 3'd0, 3'd0, 3'd4};
    start[0] = 1'b0; start[1] = 1'b0;
    npat = 8'd0; golden = 16'h0000; rsp = 6'h00;

    // Reset state
    repeat (3) tick();
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    rn = 1'b1;
    tick();

    // NPAT=0: straight to DONE, PASS reflects GOLDEN==0
    npat = 8'd0; golden = 16'h0000; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("npat0_done", {15'h0, done[0]}, 16'h1);
    chk("npat0_pass", {15'h0, pass[0]}, 16'h1);
    chk("npat0_busy", {15'h0, busy[0]}, 16'h0);
    tick();

    // Pattern sequence: flush pattern twice, then 1,0,0,4
    auto_rsp = 1'b1; rsp_base = 0;
    npat = 8'd4; golden = 16'h1234; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("seq_init1", {13'h0, pat[0]}, 16'h1);
    tick();
    chk("seq_init2", {13'h0, pat[0]}, 16'h1);
    chk("seq_init2_pv", {15'h0, pv[0]}, 16'h0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("seq_pat%0d", j), {13'h0, pat[0]}, {13'h0, seq[j]});
      chk($sformatf("seq_pv%0d", j), {15'h0, pv[0]}, 16'h1);
    end
    wait_done(0, 20, n);

    // Signature: 2A then 15 cancels back to zero
    auto_rsp = 1'b0; rsp = 6'h00;
    npat = 8'd2; golden = 16'h0000; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (3) tick();
    rsp = 6'h2A;
    tick();
    rsp = 6'h15;
    chk("sig_cap1", sig[0], 16'h002A);
    tick();
    rsp = 6'h00;
    chk("sig_final", sig[0], 16'h0000);
    chk("sig_done", {15'h0, done[0]}, 16'h1);
    chk("sig_pass", {15'h0, pass[0]}, 16'h1);

    // Latency on the RSP_LAT=3 instance
    auto_rsp = 1'b1;
    npat = 8'd5; golden = 16'hBEEF; start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    n = 0; pvcnt = 0;
    while (!done[1] && n < 40) begin
      if (pv[1]) pvcnt++;
      tick();
      n++;
    end
    chk("lat_cycles", 16'(n), 16'd10);
    chk("lat_pv_count", 16'(pvcnt), 16'd5);

    // Restart / ignore: mid-run STARTs ignored, back-to-back START in DONE cycle
    exp6 = 16'h0000;
    for (int j = 0; j < 6; j++) exp6 = lstep(exp6) ^ {10'h000, rsp_fn(4 + j)};
    npat = 8'd6; golden = exp6; start[0] = 1'b1; rsp_base = cyc;
    tick();
    start[0] = 1'b0;
    repeat (2) tick();
    npat = 8'd1; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0; npat = 8'd6;
    wait_done(0, 30, n);
    chk("restart_sig1", sig[0], exp6);
    chk("restart_pass1", {15'h0, pass[0]}, 16'h1);
    start[0] = 1'b1; rsp_base = cyc;
    tick();
    start[0] = 1'b0;
    chk("restart_done_drop", {15'h0, done[0]}, 16'h0);
    chk("restart_busy", {15'h0, busy[0]}, 16'h1);
    wait_done(0, 30, n);
    chk("restart_sig2", sig[0], exp6);
    chk("restart_pass2", {15'h0, pass[0]}, 16'h1);

    // Asynchronous reset in the middle of RUN
    npat = 8'd20; golden = 16'h0000; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (5) tick();
    chk("prerst_pv", {15'h0, pv[0]}, 16'h1);
    #2;
    rn = 1'b0;
    #1;
    chk_zero(0, "async0");
    chk_zero(1, "async1");
    tick();
    #2;
    rn = 1'b1;
    tick();
    chk("postrst_busy", {15'h0, busy[0]}, 16'h0);
    chk("postrst_done", {15'h0, done[0]}, 16'h0);
    chk("postrst_sig", sig[0], 16'h0000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
